// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: round-robin fetch/load-store arbiter for a single-port
// word memory with range/alignment rejection.   Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_SIZE = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic              OWN_I     = 1'b0;
  localparam logic              OWN_D     = 1'b1;
  localparam logic [ADDR_W-1:0] MEM_WORDS = ADDR_W'(MEM_SIZE);

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                owner_q, owner_d;
  logic                err_q, err_d;
  logic                i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic                i_err_q, i_err_d, d_err_q, d_err_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                sel_is_d;
  logic                sel_we;
  logic                sel_err;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   cap_data;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    err_d       = err_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    // On a tie the port that did not win last time takes the grant.
    sel_is_d = d_req && (!i_req || (last_gnt_q == OWN_I));
    sel_addr = sel_is_d ? d_addr : i_addr;
    sel_we   = sel_is_d && d_we;
    sel_err  = (sel_addr[1:0] != 2'b00) || ((sel_addr >> 2) >= MEM_WORDS);
    cap_data = mem_re_q ? mem_rdata : '0;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_d    = S_ACCESS;
          owner_d    = sel_is_d;
          last_gnt_d = sel_is_d;
          err_d      = sel_err;
          if (!sel_err) begin
            mem_re_d    = !sel_we;
            mem_we_d    = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_we ? d_wdata : '0;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (owner_q == OWN_D) begin
          d_ack_d   = 1'b1;
          d_err_d   = err_q;
          d_rdata_d = cap_data;
        end else begin
          i_ack_d   = 1'b1;
          i_err_d   = err_q;
          i_rdata_d = cap_data;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes are flops, so an asynchronous reset drops mem_we at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      last_gnt_q  <= OWN_D;
      owner_q     <= OWN_I;
      err_q       <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_err_q     <= i_err_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MEM_SIZE = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, i_ack, i_err;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we, d_ack, d_err;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_re, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] init_word(input int k);
    return (k == 2) ? 32'h0050_0093 : (32'h1000_0000 + 32'(k));
  endfunction

  // Word memory: combinational read, posedge write, preloaded on the first edge.
  logic [31:0] mem [0:MEM_SIZE-1];
  logic        mem_init_done = 1'b0;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < MEM_SIZE; k++) mem[k] <= init_word(k);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_mem_re", mem_re, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b1;

    // Fetch word 2
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8;
    @(negedge clk);
    chk1("f_busy", busy, 1'b1);
    chk1("f_mem_re", mem_re, 1'b1);
    chk("f_mem_addr", mem_addr, 32'h8);
    chk1("f_early_ack", i_ack, 1'b0);
    @(negedge clk);
    chk1("f_ack", i_ack, 1'b1);
    chk("f_rdata", i_rdata, 32'h0050_0093);
    chk1("f_err", i_err, 1'b0);
    chk1("f_mem_re_done", mem_re, 1'b0);
    chk1("f_d_ack", d_ack, 1'b0);
    i_req = 1'b0;
    @(negedge clk);
    chk1("f_idle_busy", busy, 1'b0);
    chk1("f_ack_pulse", i_ack, 1'b0);

    // Store 0xDEADBEEF to 0x10
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("st_mem_we", mem_we, 1'b1);
    chk1("st_mem_re", mem_re, 1'b0);
    chk("st_mem_addr", mem_addr, 32'h10);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk1("st_ack", d_ack, 1'b1);
    chk("st_rdata", d_rdata, 32'h0);
    chk1("st_err", d_err, 1'b0);
    chk1("st_mem_we_off", mem_we, 1'b0);
    chk("st_mem_word", mem[4], 32'hDEAD_BEEF);
    d_req = 1'b0;
    @(negedge clk);

    // Load 0x10; address changes after grant must not matter
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = '0;
    @(negedge clk);
    chk1("ld_mem_re", mem_re, 1'b1);
    chk("ld_mem_addr", mem_addr, 32'h10);
    d_addr = 32'h14;
    @(negedge clk);
    chk1("ld_ack", d_ack, 1'b1);
    chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("ld_i_rdata_hold", i_rdata, 32'h0050_0093);
    d_req = 1'b0;
    @(negedge clk);

    // Reset, then hold both requests: expect I,D,I,D
    rst = 1'b0;
    #1;
    chk("rst2_i_rdata", i_rdata, 32'h0);
    chk("rst2_d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tie_mem_addr", mem_addr, (k % 2 == 0) ? 32'h8 : 32'h10);
      @(negedge clk);
      chk1("tie_i_ack", i_ack, (k % 2 == 0));
      chk1("tie_d_ack", d_ack, (k % 2 == 1));
      if (k % 2 == 0) chk("tie_i_rdata", i_rdata, 32'h0050_0093);
      else            chk("tie_d_rdata", d_rdata, 32'hDEAD_BEEF);
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      chk1("tie_gap_busy", busy, 1'b0);
    end

    // Misaligned store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6; d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk1("mis_mem_we", mem_we, 1'b0);
    chk1("mis_mem_re", mem_re, 1'b0);
    chk1("mis_busy", busy, 1'b1);
    @(negedge clk);
    chk1("mis_ack", d_ack, 1'b1);
    chk1("mis_err", d_err, 1'b1);
    chk("mis_rdata", d_rdata, 32'h0);
    chk("mis_mem1", mem[1], init_word(1));
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h400;
    @(negedge clk);
    chk1("oor_wait_busy", busy, 1'b0);
    chk1("mis_err_pulse", d_err, 1'b0);
    @(negedge clk);
    chk1("oor_mem_re", mem_re, 1'b0);
    @(negedge clk);
    chk1("oor_ack", i_ack, 1'b1);
    chk1("oor_err", i_err, 1'b1);
    chk("oor_rdata", i_rdata, 32'h0);
    i_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    @(negedge clk);
    chk1("top_mem_re", mem_re, 1'b0);
    @(negedge clk);
    chk1("top_ack", i_ack, 1'b1);
    chk1("top_err", i_err, 1'b1);
    i_addr = 32'h3FC;
    @(negedge clk);
    @(negedge clk);
    chk1("last_mem_re", mem_re, 1'b1);
    chk("last_mem_addr", mem_addr, 32'h3FC);
    @(negedge clk);
    chk1("last_ack", i_ack, 1'b1);
    chk1("last_err", i_err, 1'b0);
    chk("last_rdata", i_rdata, init_word(255));
    i_req = 1'b0;
    @(negedge clk);

    // Reset during the ACCESS of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk1("ra_mem_we", mem_we, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk1("ra_mem_we_drop", mem_we, 1'b0);
    chk1("ra_busy", busy, 1'b0);
    chk("ra_mem_addr", mem_addr, 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    chk("ra_mem_word", mem[8], init_word(8));
    chk1("ra_no_ack", d_ack, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("ra_no_ack2", d_ack, 1'b0);
    chk1("ra_idle", busy, 1'b0);
    chk("ra_mem_word2", mem[8], init_word(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
